// File: rtl/cursor_blink.sv
// Cursor visibility controller: turns 0.1 s divider edges into ticks and runs a solid/blink state machine.
// Optional CURSOR_BLINK_TICK_COUNT_EN adds a free-running 16-bit tick_count output.
module cursor_blink #(
  parameter int ON_TICKS   = 5,
  parameter int OFF_TICKS  = 5,
  parameter int HOLD_TICKS = 10,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_lvl,
  input  logic        en,
  input  logic        activity,
  output logic        tick,
  output logic [1:0]  phase,
  output logic        cursor_vis
`ifdef CURSOR_BLINK_TICK_COUNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SOLID     = 2'd1;
  localparam logic [1:0] BLINK_OFF = 2'd2;
  localparam logic [1:0] BLINK_ON  = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             t1_q;
  logic             t2_q;
  logic             primed_q;
  logic             tick_q;
  logic             tick_edge;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Until primed, t2 is loaded straight from the input so the level present at reset release
  // looks like "no change" and cannot fire a tick.
  assign tick_edge = primed_q & (t1_q ^ t2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_q     <= 1'b0;
      t2_q     <= 1'b0;
      primed_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      t1_q     <= tick_lvl;
      t2_q     <= primed_q ? t1_q : tick_lvl;
      primed_q <= 1'b1;
      tick_q   <= tick_edge;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (activity) begin
      state_d = SOLID;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SOLID;
          cnt_d   = '0;
        end
        SOLID: begin
          if (tick_q) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = BLINK_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        BLINK_OFF: begin
          if (tick_q) begin
            if (cnt_q == OFF_LAST) begin
              state_d = BLINK_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        BLINK_ON: begin
          if (tick_q) begin
            if (cnt_q == ON_LAST) begin
              state_d = BLINK_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tick       = tick_q;
  assign phase      = state_q;
  assign cursor_vis = (state_q == SOLID) | (state_q == BLINK_ON);

`ifdef CURSOR_BLINK_TICK_COUNT_EN
  logic [15:0] tcnt_q;

  // Counts emitted ticks regardless of en; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= 16'd0;
    end else if (tick_q) begin
      tcnt_q <= tcnt_q + 16'd1;
    end
  end

  assign tick_count = tcnt_q;
`endif

endmodule
